arb_bus: RTL
============

Name: arb_bus

Overview:
- Parametrised successor to the datapath wired-OR bus: N sources, one registered broadcast bus.
- Sources no longer OR onto the bus unguarded. A round-robin arbiter grants one source at a time, with lock and hold-timeout support.
- The bus value is registered with 1-cycle latency and fans out to all sinks and the display output.
- Sits between the datapath units (ALU, RAM, IO, regs, CP, IND, offset) and their bus consumers.

Parameters:
- p_data_width, 16, bus width in bits.
- p_num_src, 7, number of requesting sources (>=2).
- p_max_hold, 8, maximum consecutive owned cycles before forced hand-over when others wait; 0 disables the timeout.

Ports:
- i_w_clk  input  1  clock, rising edge.
- i_w_rst_n  input  1  asynchronous active-low reset.
- i_w_req  input  p_num_src  per-source bus request.
- i_w_lock  input  p_num_src  per-source grant hold; meaningful only for the current owner.
- i_w_src_data  input  p_num_src*p_data_width  flattened source data; source k occupies bits [k*W +: W].
- o_r_gnt  output  p_num_src  one-hot registered grant, all-zero when idle.
- o_r_valid  output  1  bus holds owner data this cycle.
- o_r_bus  output  p_data_width  registered bus value to all sinks.
- o_w_disp_out  output  p_data_width  copy of o_r_bus for the display.
- o_r_timeout  output  1  one-cycle pulse on a forced hand-over.
- o_r_err_cnt  output  8  contention error count (optional feature).

Behaviour:
- Reset (async, i_w_rst_n=0), effective immediately, including mid-transfer:
  - o_r_gnt=0, o_r_valid=0, o_r_bus=0, o_r_timeout=0, o_r_err_cnt=0.
  - State IDLE, hold counter 0, RR pointer = p_num_src-1, so source 0 wins first.
- States:
  - IDLE: no owner.
  - OWNED: exactly one o_r_gnt bit set.
- Next-owner search is combinational. It scans i_w_req starting at (pointer+1) mod p_num_src and wraps. The first set bit wins.
- IDLE transitions:
  - Any req at edge: grant the winner. Load o_r_gnt, set pointer to the winner, load o_r_bus with the winner's data, o_r_valid=1, go to OWNED, hold counter=1.
  - No req: stay IDLE with o_r_bus=0 and o_r_valid=0.
- OWNED, owner keeps bus (owner req=1 or owner lock=1, and no timeout): reload o_r_bus from the owner's data each edge. Hold counter increments and saturates at p_max_hold.
- OWNED, release (owner req=0 and lock=0):
  - Another req pending: switch at the same edge (back-to-back, no idle cycle). Search excludes the owner. Counter=1.
  - No other req: go to IDLE at that edge. o_r_gnt=0, o_r_valid=0, o_r_bus=0.
- OWNED, timeout:
  - Condition: p_max_hold!=0, counter==p_max_hold, and any non-owner req pending.
  - Forced switch to the next non-owner requester regardless of lock. o_r_timeout=1 for that one cycle, aligned with the new grant. Counter=1.
- Timeout with no other requester: the owner keeps the bus and no pulse is generated.
- Latency: data presented at edge t appears on o_r_bus after edge t (1 cycle). Grant and data change at the same edge.
- Invariants: o_r_gnt is never multi-hot. o_r_bus=0 whenever o_r_valid=0. o_w_disp_out always equals o_r_bus.

Optional Feature:
- Macro: ARB_BUS_SNOOP_EN.
- Defined: a contention monitor runs in parallel.
  - Each edge, count 1 if any source without a grant (either not in the next grant, or all sources when the next state is IDLE) has nonzero i_w_src_data. Such a source is violating the drive-zero-when-idle rule.
  - o_r_err_cnt increments by 1 per offending cycle and saturates at 255. Reset clears it.
- Undefined: o_r_err_cnt is tied to 0 and no monitor logic is built. All other behaviour is identical.

Test Plan (W=16, N=4, p_max_hold=4):
- Reset then req=0001, data0=0x1234 -> next cycle gnt=0001, valid=1, bus=0x1234, disp_out=0x1234.
- req=1111 held with lock=0, each source drops req one cycle after its grant -> grant order 0001, 0010, 0100, 1000, no idle cycles between grants.
- Owner 0 holds req=1, req1=1 pending -> after 4 owned cycles gnt=0010 and timeout=1 for exactly 1 cycle. With only req0, source 0 stays with no pulse.
- Owner drops req but lock=1 -> grant kept. Lock drops with no other req -> next cycle gnt=0, valid=0, bus=0x0000.
- Assert i_w_rst_n=0 mid-OWNED between clock edges -> outputs go to 0 immediately. After release with req=1000, pointer is reset so that with req=1001, source 0 is granted first.
- ARB_BUS_SNOOP_EN: owner 0, source 2 drives 0xFFFF for 3 cycles -> err_cnt=3. 300 offending cycles -> err_cnt=255 (saturated). Macro undefined -> err_cnt=0.

Source files
------------

// File: rtl/arb_bus.sv
// Round-robin arbitrated, registered broadcast bus with owner lock and hold timeout.
// Optional contention monitor on o_r_err_cnt is built when ARB_BUS_SNOOP_EN is defined.
module arb_bus #(
  parameter int p_data_width = 16,
  parameter int p_num_src    = 7,
  parameter int p_max_hold   = 8
) (
  input  logic                              i_w_clk,
  input  logic                              i_w_rst_n,
  input  logic [p_num_src-1:0]              i_w_req,
  input  logic [p_num_src-1:0]              i_w_lock,
  input  logic [p_num_src*p_data_width-1:0] i_w_src_data,
  output logic [p_num_src-1:0]              o_r_gnt,
  output logic                              o_r_valid,
  output logic [p_data_width-1:0]           o_r_bus,
  output logic [p_data_width-1:0]           o_w_disp_out,
  output logic                              o_r_timeout,
  output logic [7:0]                        o_r_err_cnt
);

  localparam int PTR_W  = (p_num_src > 1) ? $clog2(p_num_src) : 1;
  localparam int HOLD_W = $clog2(p_max_hold + 2);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(p_max_hold);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(p_num_src - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                   state_q, state_d;
  logic [p_num_src-1:0]     gnt_q, gnt_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic                     valid_q, valid_d;
  logic [p_data_width-1:0]  bus_q, bus_d;
  logic                     timeout_q, timeout_d;

  logic [p_data_width-1:0]  src_arr [p_num_src];
  logic [p_num_src-1:0]     req_m;
  logic [PTR_W-1:0]         cand, win;
  logic                     found;
  logic                     owner_keep, others, timeout_hit;

  for (genvar k = 0; k < p_num_src; k++) begin : g_unpack
    assign src_arr[k] = i_w_src_data[k*p_data_width +: p_data_width];
  end

  // Scan starts just after the pointer; in OWNED the pointer is the owner, so it is scanned last and masked.
  always_comb begin
    req_m = (state_q == OWNED) ? (i_w_req & ~gnt_q) : i_w_req;
    found = 1'b0;
    win   = ptr_q;
    cand  = ptr_q;
    for (int i = 0; i < p_num_src; i++) begin
      cand = (cand == PTR_LAST) ? '0 : cand + 1'b1;
      if (!found && req_m[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign owner_keep  = |((i_w_req | i_w_lock) & gnt_q);
  assign others      = |(i_w_req & ~gnt_q);
  assign timeout_hit = (p_max_hold != 0) && (hold_q == HOLD_MAX) && others;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    valid_d   = valid_q;
    bus_d     = bus_q;
    timeout_d = 1'b0;
    if ((state_q == OWNED) && !timeout_hit && owner_keep) begin
      bus_d  = src_arr[ptr_q];
      hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
    end else if (found) begin
      state_d    = OWNED;
      gnt_d      = '0;
      gnt_d[win] = 1'b1;
      ptr_d      = win;
      hold_d     = HOLD_W'(1);
      valid_d    = 1'b1;
      bus_d      = src_arr[win];
      timeout_d  = timeout_hit;
    end else begin
      state_d = IDLE;
      gnt_d   = '0;
      hold_d  = '0;
      valid_d = 1'b0;
      bus_d   = '0;
    end
  end

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ptr_q     <= PTR_LAST;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      bus_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      bus_q     <= bus_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_r_gnt      = gnt_q;
  assign o_r_valid    = valid_q;
  assign o_r_bus      = bus_q;
  assign o_w_disp_out = bus_q;
  assign o_r_timeout  = timeout_q;

`ifdef ARB_BUS_SNOOP_EN
  // A source outside the next grant must drive zero; count cycles where any does not.
  logic [p_num_src-1:0] offend_vec;
  logic [7:0]           err_q, err_d;

  for (genvar k = 0; k < p_num_src; k++) begin : g_snoop
    assign offend_vec[k] = ~gnt_d[k] & (|src_arr[k]);
  end

  always_comb begin
    err_d = err_q;
    if ((|offend_vec) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) err_q <= 8'd0;
    else            err_q <= err_d;
  end

  assign o_r_err_cnt = err_q;
`else
  assign o_r_err_cnt = 8'd0;
`endif

endmodule
